// File: rtl/add_functional_unit.sv
// ADD execution unit: fixed-latency 8-bit adder, credit-throttled result queue, CDB broadcast.
// Define ADD_SAT_EN for an unsigned saturating add; default build wraps and drops the carry.
module add_functional_unit #(
    parameter int DATA_W    = 8,
    parameter int TAG_W     = 3,
    parameter int LATENCY   = 2,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AR_Status,
    input  logic [DATA_W-1:0] ADD_Operand1,
    input  logic [DATA_W-1:0] ADD_Operand2,
    input  logic [TAG_W-1:0]  ADD_Tag_ip,
    output logic              ADD_Status,
    output logic              CDB_req,
    input  logic              CDB_grant,
    output logic [DATA_W-1:0] CDB_Data,
    output logic [TAG_W-1:0]  CDB_Tag,
    output logic              CDB_Vbit
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

    typedef struct packed {
        logic              v;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } pipe_t;

    pipe_t             pipe_q [LATENCY];
    logic [DATA_W-1:0] q_data [BUF_DEPTH];
    logic [TAG_W-1:0]  q_tag  [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  credits;

    logic              issue;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] sum;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Status and request come straight from registers, so the
    // station never sees a combinational loop through AR_Status.
    assign ADD_Status = (credits == '0);
    assign CDB_req    = (count != '0);
    assign CDB_Vbit   = CDB_req & CDB_grant;
    assign CDB_Data   = CDB_req ? q_data[rd_ptr] : '0;
    assign CDB_Tag    = CDB_req ? q_tag[rd_ptr]  : '0;

    assign issue = AR_Status & ~ADD_Status;
    assign pop   = CDB_Vbit;
    assign push  = pipe_q[LATENCY-1].v;

`ifdef ADD_SAT_EN
    logic [DATA_W:0] sum_wide;

    always_comb begin
        sum_wide = {1'b0, ADD_Operand1} + {1'b0, ADD_Operand2};
        sum      = sum_wide[DATA_W] ? '1 : sum_wide[DATA_W-1:0];
    end
`else
    always_comb begin
        sum = ADD_Operand1 + ADD_Operand2;
    end
`endif

    // Pipeline never stalls: credits reserve a queue slot per op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0].v <= issue;
            if (issue) begin
                pipe_q[0].tag  <= ADD_Tag_ip;
                pipe_q[0].data <= sum;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= pipe_q[LATENCY-1].data;
            q_tag[wr_ptr]  <= pipe_q[LATENCY-1].tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            unique case (1'b1)
                (push & ~pop): count <= count + 1'b1;
                (pop & ~push): count <= count - 1'b1;
                default:       count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CNT_FULL;
        end else begin
            unique case (1'b1)
                (issue & ~pop): credits <= credits - 1'b1;
                (pop & ~issue): credits <= credits + 1'b1;
                default:        credits <= credits;
            endcase
        end
    end

endmodule

// File: tb/tb_add_functional_unit.sv
// Directed bench for add_functional_unit (LATENCY=2, BUF_DEPTH=2).
// Inputs change 1ns after posedge; outputs are checked there as well.
module tb_add_functional_unit;

    logic       clk;
    logic       rst;
    logic       AR_Status;
    logic [7:0] ADD_Operand1;
    logic [7:0] ADD_Operand2;
    logic [2:0] ADD_Tag_ip;
    logic       ADD_Status;
    logic       CDB_req;
    logic       CDB_grant;
    logic [7:0] CDB_Data;
    logic [2:0] CDB_Tag;
    logic       CDB_Vbit;

    int checks;
    int failures;

`ifdef ADD_SAT_EN
    localparam logic [7:0] OVF_SUM = 8'hFF;
`else
    localparam logic [7:0] OVF_SUM = 8'h10;
`endif

    add_functional_unit #(
        .DATA_W(8), .TAG_W(3), .LATENCY(2), .BUF_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .AR_Status(AR_Status),
        .ADD_Operand1(ADD_Operand1),
        .ADD_Operand2(ADD_Operand2),
        .ADD_Tag_ip(ADD_Tag_ip),
        .ADD_Status(ADD_Status),
        .CDB_req(CDB_req),
        .CDB_grant(CDB_grant),
        .CDB_Data(CDB_Data),
        .CDB_Tag(CDB_Tag),
        .CDB_Vbit(CDB_Vbit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] t);
        AR_Status    = v;
        ADD_Operand1 = a;
        ADD_Operand2 = b;
        ADD_Tag_ip   = t;
    endtask

    task automatic chk_cdb(input string name, input logic req,
                           input logic vb, input logic [7:0] d,
                           input logic [2:0] t);
        chk({name, "_req"},  CDB_req,  req);
        chk({name, "_vbit"}, CDB_Vbit, vb);
        chk({name, "_data"}, CDB_Data, d);
        chk({name, "_tag"},  CDB_Tag,  t);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        CDB_grant = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        tick();
        tick();
        chk("rst_status", ADD_Status, 1'b0);
        chk_cdb("rst", 1'b0, 1'b0, 8'h00, 3'd0);
        rst = 1'b0;
        tick();

        // single op, grant held high
        CDB_grant = 1'b1;
        drive(1'b1, 8'h05, 8'h0A, 3'd1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        chk("t1_status_e0", ADD_Status, 1'b0);
        chk("t1_req_e0", CDB_req, 1'b0);
        tick();
        chk("t1_req_e1", CDB_req, 1'b0);
        tick();
        chk_cdb("t1_e2", 1'b1, 1'b1, 8'h0F, 3'd1);
        tick();
        chk_cdb("t1_e3", 1'b0, 1'b0, 8'h00, 3'd0);

        // back-pressure
        CDB_grant = 1'b0;
        drive(1'b1, 8'h01, 8'h02, 3'd2);
        tick();
        chk("t2_status_1", ADD_Status, 1'b0);
        drive(1'b1, 8'h03, 8'h04, 3'd3);
        tick();
        chk("t2_status_2", ADD_Status, 1'b1);
        drive(1'b1, 8'h09, 8'h09, 3'd5);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        chk("t2_status_3", ADD_Status, 1'b1);
        chk_cdb("t2_head_a", 1'b1, 1'b0, 8'h03, 3'd2);
        tick();
        chk_cdb("t2_head_b", 1'b1, 1'b0, 8'h03, 3'd2);
        tick();
        chk("t2_status_hold", ADD_Status, 1'b1);
        CDB_grant = 1'b1;
        #1;
        chk("t2_vbit_on", CDB_Vbit, 1'b1);
        tick();
        chk("t2_status_pop1", ADD_Status, 1'b0);
        chk_cdb("t2_pop1", 1'b1, 1'b1, 8'h07, 3'd3);
        tick();
        chk_cdb("t2_pop2", 1'b0, 1'b0, 8'h00, 3'd0);
        tick();
        tick();
        chk("t2_no_ghost", CDB_req, 1'b0);
        chk("t2_status_end", ADD_Status, 1'b0);

        // overflow
        drive(1'b1, 8'hF0, 8'h20, 3'd6);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        tick();
        tick();
        chk_cdb("t3_ovf", 1'b1, 1'b1, OVF_SUM, 3'd6);
        tick();
        chk("t3_req_off", CDB_req, 1'b0);

        // pop and write in the same cycle, then issue with pop
        CDB_grant = 1'b0;
        drive(1'b1, 8'h10, 8'h01, 3'd0);
        tick();
        drive(1'b1, 8'h20, 8'h02, 3'd7);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        tick();
        chk("t4_status_full", ADD_Status, 1'b1);
        chk_cdb("t4_head0", 1'b1, 1'b0, 8'h11, 3'd0);
        CDB_grant = 1'b1;
        tick();
        chk("t4_status_pw", ADD_Status, 1'b0);
        chk_cdb("t4_pw", 1'b1, 1'b1, 8'h22, 3'd7);
        drive(1'b1, 8'h7F, 8'h01, 3'd3);
        tick();
        chk("t4_status_ip", ADD_Status, 1'b0);
        chk("t4_req_ip", CDB_req, 1'b0);
        drive(1'b1, 8'h01, 8'h01, 3'd5);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        chk("t4_status_2fly", ADD_Status, 1'b1);
        chk("t4_req_2fly", CDB_req, 1'b0);
        tick();
        chk_cdb("t4_z", 1'b1, 1'b1, 8'h80, 3'd3);
        tick();
        chk("t4_status_pw2", ADD_Status, 1'b0);
        chk_cdb("t4_w", 1'b1, 1'b1, 8'h02, 3'd5);
        tick();
        chk_cdb("t4_empty", 1'b0, 1'b0, 8'h00, 3'd0);

        // grant without request
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_vbit", CDB_Vbit, 1'b0);
            chk("t5_req", CDB_req, 1'b0);
            chk("t5_status", ADD_Status, 1'b0);
        end

        // reset mid-flight
        drive(1'b1, 8'h01, 8'h01, 3'd4);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_status_rst", ADD_Status, 1'b0);
        chk_cdb("t6_rst", 1'b0, 1'b0, 8'h00, 3'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_status", ADD_Status, 1'b0);
            chk("t6_vbit", CDB_Vbit, 1'b0);
            chk("t6_tag", CDB_Tag, 3'd0);
        end

        // unit is usable again after reset
        drive(1'b1, 8'h22, 8'h11, 3'd2);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        tick();
        tick();
        chk_cdb("t6_after", 1'b1, 1'b1, 8'h33, 3'd2);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
